// File: rtl/maze_mem.sv
// Maze wall/visited memory: row-serial loader, then a solver read/mark port.
// Optional visit statistics counters are built only when MAZE_MEM_STATS_EN is defined.
module maze_mem #(
  parameter  int unsigned maze_width = 6,
  localparam int unsigned N          = 1 << maze_width,
  localparam int unsigned CW         = 2 * maze_width + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [N-1:0]          load_data,
  output logic                  load_done,
  input  logic [maze_width-1:0] row,
  input  logic [maze_width-1:0] col,
  input  logic                  maze_oe,
  input  logic                  maze_we,
  output logic                  maze_in,
  output logic                  wall_hit,
  output logic [CW-1:0]         mark_count,
  output logic [CW-1:0]         revisit_count
);

  localparam logic [0:0] ST_LOAD  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [maze_width-1:0] ptr_q, ptr_d;
  logic                  load_ready_q, load_ready_d;
  logic                  load_done_q, load_done_d;
  logic                  maze_in_q, maze_in_d;
  logic                  wall_hit_q, wall_hit_d;

  logic [N-1:0] wall_q [N];
  logic         accept_c;
  logic         wall_bit_c;

  assign accept_c   = (state_q == ST_LOAD) && load_valid;
  assign wall_bit_c = wall_q[row][col];

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    load_ready_d = load_ready_q;
    load_done_d  = load_done_q;
    maze_in_d    = maze_in_q;
    wall_hit_d   = wall_hit_q;
    case (state_q)
      ST_LOAD: begin
        load_ready_d = 1'b1;
        maze_in_d    = 1'b0;
        if (load_valid) begin
          ptr_d = ptr_q + maze_width'(1);
          if (ptr_q == maze_width'(N - 1)) begin
            state_d      = ST_SERVE;
            load_ready_d = 1'b0;
            load_done_d  = 1'b1;
          end
        end
      end
      ST_SERVE: begin
        if (maze_oe) maze_in_d = wall_bit_c;
        if (maze_we && wall_bit_c) wall_hit_d = 1'b1;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      ptr_q        <= '0;
      load_ready_q <= 1'b1;
      load_done_q  <= 1'b0;
      maze_in_q    <= 1'b0;
      wall_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      maze_in_q    <= maze_in_d;
      wall_hit_q   <= wall_hit_d;
    end
  end

  // Wall storage is written only by the loader; no reset needed since every row is reloaded
  always_ff @(posedge clk) begin
    if (!rst && accept_c) wall_q[ptr_q] <= load_data;
  end

`ifdef MAZE_MEM_STATS_EN
  // Visited bits are only observable through the counters, so they live with them
  logic [N-1:0]  mark_q [N];
  logic [CW-1:0] mark_cnt_q, mark_cnt_d;
  logic [CW-1:0] revisit_q, revisit_d;
  logic          mark_hit_c;

  assign mark_hit_c = (state_q == ST_SERVE) && maze_we && !wall_bit_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept_c)        mark_q[ptr_q]    <= '0;
      else if (mark_hit_c) mark_q[row][col] <= 1'b1;
    end
  end

  always_comb begin
    mark_cnt_d = mark_cnt_q;
    revisit_d  = revisit_q;
    if (mark_hit_c) begin
      if (mark_q[row][col]) begin
        if (!(&revisit_q)) revisit_d = revisit_q + CW'(1);
      end else begin
        if (!(&mark_cnt_q)) mark_cnt_d = mark_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mark_cnt_q <= '0;
      revisit_q  <= '0;
    end else begin
      mark_cnt_q <= mark_cnt_d;
      revisit_q  <= revisit_d;
    end
  end

  assign mark_count    = mark_cnt_q;
  assign revisit_count = revisit_q;
`else
  assign mark_count    = '0;
  assign revisit_count = '0;
`endif

  assign load_ready = load_ready_q;
  assign load_done  = load_done_q;
  assign maze_in    = maze_in_q;
  assign wall_hit   = wall_hit_q;

endmodule

// File: tb/tb_maze_mem.sv
// Self-checking bench for maze_mem: random stimulus against an array-based maze model.
// Counter expectations follow MAZE_MEM_STATS_EN as defined for the build.
module tb_maze_mem;

  localparam int W   = 6;
  localparam int N   = 64;
  localparam int CW  = 13;
  localparam int MAX = (1 << CW) - 1;
`ifdef MAZE_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [N-1:0]  load_data = '0;
  logic          load_done;
  logic [W-1:0]  row = '0;
  logic [W-1:0]  col = '0;
  logic          maze_oe = 1'b0;
  logic          maze_we = 1'b0;
  logic          maze_in;
  logic          wall_hit;
  logic [CW-1:0] mark_count;
  logic [CW-1:0] revisit_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit [N-1:0] wall_m [N];
  bit [N-1:0] mark_m [N];
  bit load_m, done_m, in_m, hit_m;
  int ptr_m, mc_m, rc_m;

  maze_mem #(.maze_width(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_done(load_done), .row(row), .col(col),
    .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in), .wall_hit(wall_hit),
    .mark_count(mark_count), .revisit_count(revisit_count)
  );

  always #5 clk = ~clk;

  // Apply one clock edge to the model using the inputs currently driven
  task automatic model_edge();
    if (rst) begin
      load_m = 1; ptr_m = 0; done_m = 0; in_m = 0; hit_m = 0; mc_m = 0; rc_m = 0;
    end else if (load_m) begin
      if (load_valid) begin
        wall_m[ptr_m] = load_data;
        mark_m[ptr_m] = '0;
        if (ptr_m == N - 1) begin load_m = 0; done_m = 1; end
        ptr_m = (ptr_m + 1) % N;
      end
    end else begin
      if (maze_oe) in_m = wall_m[row][col];
      if (maze_we) begin
        if (wall_m[row][col]) hit_m = 1;
        else begin
          if (mark_m[row][col]) begin
            if (STATS && rc_m < MAX) rc_m++;
          end else if (STATS && mc_m < MAX) mc_m++;
          mark_m[row][col] = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] row_pattern(int r);
    logic [N-1:0] v;
    v = {$urandom, $urandom};
    if (r == 5)  begin v[8] = 1'b1;  v[9] = 1'b0;  end
    if (r == 10) begin v[10] = 1'b0; v[11] = 1'b0; end
    return v;
  endfunction

  function automatic logic [4+2*CW-1:0] exp_vec();
    return {load_m, done_m, in_m, hit_m, CW'(mc_m), CW'(rc_m)};
  endfunction

  task automatic test_reset();
    rst = 1; load_valid = $urandom_range(0, 1); maze_oe = 1; maze_we = 1;
    row = W'($urandom); col = W'($urandom); load_data = {$urandom, $urandom};
    cycle(); cycle();
    tests++; if (load_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", load_done); end
    tests++; if (maze_in !== 1'b0) begin fails++; $display("FAIL reset_maze_in: got %b want 0", maze_in); end
    tests++; if (wall_hit !== 1'b0) begin fails++; $display("FAIL reset_wall_hit: got %b want 0", wall_hit); end
    tests++; if (mark_count !== '0 || revisit_count !== '0) begin
      fails++; $display("FAIL reset_counts: got %0d/%0d want 0/0", mark_count, revisit_count);
    end
    rst = 0; load_valid = 0; maze_oe = 0; maze_we = 0;
  endtask

  // Load with random gaps; solver-port activity during load must be ignored
  task automatic test_load();
    int hs = 0;
    bit ok = 1;
    for (int cyc = 0; cyc < 2000 && !load_done; cyc++) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = row_pattern(ptr_m);
      maze_oe = $urandom_range(0, 1); maze_we = $urandom_range(0, 1);
      row = W'($urandom); col = W'($urandom);
      if (load_valid && load_ready) hs++;
      cycle();
      if ({load_ready, load_done, maze_in, wall_hit, mark_count, revisit_count} !== exp_vec()) begin
        ok = 0; $display("FAIL load_cycle%0d: got %h want %h", cyc,
          {load_ready, load_done, maze_in, wall_hit, mark_count, revisit_count}, exp_vec());
      end
    end
    tests++; if (!ok) fails++;
    tests++; if (load_done !== 1'b1) begin fails++; $display("FAIL load_timeout: load_done got %b want 1", load_done); end
    tests++; if (hs != N) begin fails++; $display("FAIL load_handshakes: got %0d want %0d", hs, N); end
    maze_oe = 0; maze_we = 0;
  endtask

  task automatic test_ignore_load();
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = {$urandom, $urandom};
      cycle();
      tests++; if (load_ready !== 1'b0 || load_done !== 1'b1) begin
        fails++; $display("FAIL serve_ignores_load: ready/done got %b%b want 01", load_ready, load_done);
      end
    end
    load_valid = 0;
  endtask

  task automatic test_read();
    maze_oe = 1; row = 5; col = 8; cycle();
    tests++; if (maze_in !== 1'b1) begin fails++; $display("FAIL read_5_8: got %b want 1", maze_in); end
    col = 9; cycle();
    tests++; if (maze_in !== 1'b0) begin fails++; $display("FAIL read_5_9: got %b want 0", maze_in); end
    maze_oe = 0; col = 8;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++; if (maze_in !== 1'b0) begin fails++; $display("FAIL read_hold: got %b want 0", maze_in); end
    end
    for (int i = 0; i < 40; i++) begin
      maze_oe = $urandom_range(0, 1); row = W'($urandom); col = W'($urandom);
      cycle();
      tests++; if (maze_in !== in_m) begin
        fails++; $display("FAIL read_random(%0d,%0d): got %b want %b", row, col, maze_in, in_m);
      end
    end
    maze_oe = 0;
  endtask

  task automatic test_mark();
    maze_we = 1; row = 10; col = 10; cycle(); cycle();
    col = 11; cycle();
    maze_we = 0; cycle();
    tests++; if (mark_count !== CW'(STATS ? 2 : 0) || mark_count !== CW'(mc_m)) begin
      fails++; $display("FAIL mark_count: got %0d want %0d", mark_count, mc_m);
    end
    tests++; if (revisit_count !== CW'(STATS ? 1 : 0) || revisit_count !== CW'(rc_m)) begin
      fails++; $display("FAIL revisit_count: got %0d want %0d", revisit_count, rc_m);
    end
    tests++; if (wall_hit !== 1'b0) begin fails++; $display("FAIL mark_wall_hit: got %b want 0", wall_hit); end
  endtask

  task automatic test_wall_hit();
    logic [CW-1:0] mc0, rc0;
    mc0 = CW'(mc_m); rc0 = CW'(rc_m);
    maze_we = 1; maze_oe = 1; row = 5; col = 8; cycle();
    maze_we = 0; maze_oe = 0;
    tests++; if (wall_hit !== 1'b1) begin fails++; $display("FAIL wall_hit_set: got %b want 1", wall_hit); end
    tests++; if (maze_in !== 1'b1) begin fails++; $display("FAIL wall_read_both: got %b want 1", maze_in); end
    tests++; if (mark_count !== mc0 || revisit_count !== rc0) begin
      fails++; $display("FAIL wall_counts: got %0d/%0d want %0d/%0d", mark_count, revisit_count, mc0, rc0);
    end
    for (int i = 0; i < 3; i++) cycle();
    tests++; if (wall_hit !== 1'b1) begin fails++; $display("FAIL wall_hit_sticky: got %b want 1", wall_hit); end
    maze_oe = 1; cycle(); maze_oe = 0;
    tests++; if (maze_in !== 1'b1) begin fails++; $display("FAIL wall_unchanged: got %b want 1", maze_in); end
  endtask

  task automatic test_random_serve(input int n);
    for (int i = 0; i < n; i++) begin
      maze_oe = $urandom_range(0, 1); maze_we = ($urandom_range(0, 2) == 0);
      row = W'($urandom_range(0, 7)); col = W'($urandom_range(0, 7));
      cycle();
      tests++;
      if ({load_ready, load_done, maze_in, wall_hit, mark_count, revisit_count} !== exp_vec()) begin
        fails++; $display("FAIL serve_random%0d: got %h want %h", i,
          {load_ready, load_done, maze_in, wall_hit, mark_count, revisit_count}, exp_vec());
      end
    end
    maze_oe = 0; maze_we = 0;
  endtask

  task automatic test_reset_midload();
    rst = 1; cycle(); rst = 0;
    for (int i = 0; i < 30; i++) begin load_valid = 1; load_data = row_pattern(i); cycle(); end
    rst = 1; cycle(); rst = 0; load_valid = 0;
    tests++; if (load_done !== 1'b0 || load_ready !== 1'b1) begin
      fails++; $display("FAIL midload_reset: ready/done got %b%b want 10", load_ready, load_done);
    end
    tests++; if (mark_count !== '0 || revisit_count !== '0 || wall_hit !== 1'b0) begin
      fails++; $display("FAIL midload_reset_stats: got %0d/%0d/%b want 0/0/0", mark_count, revisit_count, wall_hit);
    end
    for (int i = 0; i < N; i++) begin
      load_valid = 1; load_data = row_pattern(i); cycle();
      tests++;
      if (load_done !== (i == N - 1) || load_ready !== (i != N - 1)) begin
        fails++; $display("FAIL reload_row%0d: ready/done got %b%b want %b%b", i,
          load_ready, load_done, i != N - 1, i == N - 1);
      end
    end
    load_valid = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_ignore_load();
    test_read();
    test_mark();
    test_wall_hit();
    test_random_serve(200);
    test_reset_midload();
    test_read();
    test_mark();
    test_random_serve(150);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
